// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM state
// encoding, status flag bundle and the word geometry.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_BYTE   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_e;

    typedef struct packed {
        logic busy;
        logic cpu_hold;
        logic done;
        logic error;
    } status_t;

    localparam status_t STAT_IDLE    = '{busy: 1'b0, cpu_hold: 1'b0, done: 1'b0, error: 1'b0};
    localparam status_t STAT_LOADING = '{busy: 1'b1, cpu_hold: 1'b1, done: 1'b0, error: 1'b0};
    localparam status_t STAT_DONE    = '{busy: 1'b0, cpu_hold: 1'b0, done: 1'b1, error: 1'b0};
    // A failed load keeps the CPU stalled so it never runs a corrupt image.
    localparam status_t STAT_ERROR   = '{busy: 1'b0, cpu_hold: 1'b1, done: 1'b0, error: 1'b1};

    // States in which the byte stream is being consumed.
    function automatic logic rx_open(input state_e s);
        return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_BYTE) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader owns the master side; the stream source and memory form the slave side.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_write;
    logic                  mem_ack;

    modport master (
        input  rx_data, rx_valid, mem_ack,
        output rx_ready, mem_addr, mem_wdata, mem_write
    );

    modport slave (
        output rx_data, rx_valid, mem_ack,
        input  rx_ready, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into a 32-bit word; flags the byte that completes it.
// The word register is the memory write data, so it must not change outside a load.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [31:0]           word_q, word_d;

    // NOTE: every always_comb target gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d = '0;
        end else if (load) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_in;
            idx_d = idx_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    assign word_full = load && !clear && (idx_q == BYTE_IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses <count><payload><xor checksum>, writes each
// word through a write/ack port and stalls the CPU until the image verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MAX_WORDS  = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.master bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  words_written
);

    state_e                state_q, state_d;
    status_t               stat_q, stat_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]           words_q, words_d;
    logic [15:0]           count_q, count_d;
    logic [7:0]            acc_q, acc_d;

    logic        transfer;
    logic        asm_clear;
    logic        asm_load;
    logic        word_full;
    logic [31:0] asm_word;
    logic [15:0] count_full;
    logic [15:0] words_inc;

    assign transfer   = bus.rx_valid && rx_ready_q;
    assign count_full = {bus.rx_data, count_q[7:0]};
    assign words_inc  = words_q + 16'd1;

    imem_loader_word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .load      (asm_load),
        .byte_in   (bus.rx_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    always_comb begin
        state_d    = state_q;
        stat_d     = stat_q;
        mem_addr_d = mem_addr_q;
        words_d    = words_q;
        count_d    = count_q;
        acc_d      = acc_q;
        asm_clear  = 1'b0;
        asm_load   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_CNT_LO;
                    stat_d     = STAT_LOADING;
                    words_d    = '0;
                    mem_addr_d = BASE_ADDR;
                    acc_d      = '0;
                    asm_clear  = 1'b1;
                end
            end

            ST_CNT_LO: begin
                if (transfer) begin
                    count_d[7:0] = bus.rx_data;
                    acc_d        = acc_q ^ bus.rx_data;
                    state_d      = ST_CNT_HI;
                end
            end

            ST_CNT_HI: begin
                if (transfer) begin
                    count_d[15:8] = bus.rx_data;
                    acc_d         = acc_q ^ bus.rx_data;
                    asm_clear     = 1'b1;
                    if (32'(count_full) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        stat_d  = STAT_ERROR;
                    end else if (count_full == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_BYTE;
                    end
                end
            end

            ST_BYTE: begin
                if (transfer) begin
                    asm_load = 1'b1;
                    acc_d    = acc_q ^ bus.rx_data;
                    if (word_full) state_d = ST_WRITE;
                end
            end

            // Address and data are registers untouched in this state, so they
            // stay stable for however long the memory withholds mem_ack.
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(WORD_BYTES);
                    words_d    = words_inc;
                    state_d    = (words_inc == count_q) ? ST_CHECK : ST_BYTE;
                end
            end

            ST_CHECK: begin
                if (transfer) begin
                    if (bus.rx_data == acc_q) begin
                        state_d = ST_DONE;
                        stat_d  = STAT_DONE;
                    end else begin
                        state_d = ST_ERROR;
                        stat_d  = STAT_ERROR;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered from the next state so they are
        // glitch-free and line up with the state they belong to.
        rx_ready_d  = rx_open(state_d);
        mem_write_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            stat_q      <= STAT_IDLE;
            rx_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            words_q     <= '0;
            count_q     <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            rx_ready_q  <= rx_ready_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            words_q     <= words_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = asm_word;

    assign busy          = stat_q.busy;
    assign cpu_hold      = stat_q.cpu_hold;
    assign done          = stat_q.done;
    assign error         = stat_q.error;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of complete load scenarios plus
// hand-written sequences for count overflow, mid-load start and mid-load reset.
module tb_imem_loader;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cpu_hold, busy, done, error;
    logic [15:0] words_written;

    imem_loader_if #(.ADDR_WIDTH(32)) bus ();

    imem_loader #(
        .ADDR_WIDTH (32),
        .BASE_ADDR  (32'h0),
        .MAX_WORDS  (256)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: raises mem_ack once a request has been seen for ack_delay
    // negedges, logs every completed write, and counts unstable addr/data.
    int          ack_delay    = 1;
    bit          stray_ack    = 1'b0;
    int          wcnt         = 0;
    int          write_cycles = 0;
    int          unstable_cnt = 0;
    logic [31:0] cap_addr, cap_data;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_len  [$];

    initial bus.mem_ack = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_write === 1'b1) begin
            if (wcnt == 0) begin
                cap_addr = bus.mem_addr;
                cap_data = bus.mem_wdata;
            end else if (bus.mem_addr !== cap_addr || bus.mem_wdata !== cap_data) begin
                unstable_cnt++;
            end
            wcnt++;
            write_cycles++;
            if (wcnt >= ack_delay) begin
                bus.mem_ack = 1'b1;
                wr_addr.push_back(cap_addr);
                wr_data.push_back(cap_data);
                wr_len.push_back(wcnt);
            end else begin
                bus.mem_ack = 1'b0;
            end
        end else begin
            wcnt        = 0;
            bus.mem_ack = stray_ack;
        end
    end

    // All driving and sampling happens on negedges, away from the active edge.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("rx_ready_timeout", bus.rx_ready, 1'b1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct packed {
        int              n;
        logic [0:2][31:0] w;
        logic [7:0]      cs_mask;
        int              ack_delay;
        bit              stray;
        bit              exp_done;
        bit              exp_error;
        bit              exp_hold;
        logic [15:0]     exp_words;
        logic [31:0]     exp_end_addr;
    } vec_t;

    vec_t vecs [4];

    task automatic run_load(input vec_t v, input string tag);
        logic [7:0] cs;
        logic [7:0] b;
        int base, wc_base, us_base;
        base      = wr_addr.size();
        wc_base   = write_cycles;
        us_base   = unstable_cnt;
        ack_delay = v.ack_delay;
        stray_ack = v.stray;

        pulse_start();
        check({tag, ":busy_after_start"}, busy, 1'b1);
        check({tag, ":hold_after_start"}, cpu_hold, 1'b1);
        check({tag, ":done_after_start"}, done, 1'b0);
        check({tag, ":error_after_start"}, error, 1'b0);
        check({tag, ":words_after_start"}, words_written, 16'd0);
        check({tag, ":addr_after_start"}, bus.mem_addr, 32'h0);

        cs = v.n[7:0] ^ v.n[15:8];
        send_byte(v.n[7:0]);
        send_byte(v.n[15:8]);
        for (int i = 0; i < v.n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b  = v.w[i][8*j +: 8];
                cs = cs ^ b;
                send_byte(b);
                if (i == 0 && j == 3) begin
                    check({tag, ":write_1cyc_after_6th_byte"}, bus.mem_write, 1'b1);
                    check({tag, ":rx_ready_low_in_write"}, bus.rx_ready, 1'b0);
                end
            end
        end
        send_byte(cs ^ v.cs_mask);

        check({tag, ":done"}, done, v.exp_done);
        check({tag, ":error"}, error, v.exp_error);
        check({tag, ":busy_end"}, busy, 1'b0);
        check({tag, ":cpu_hold"}, cpu_hold, v.exp_hold);
        check({tag, ":words_written"}, words_written, v.exp_words);
        check({tag, ":mem_addr_end"}, bus.mem_addr, v.exp_end_addr);
        check({tag, ":n_writes"}, wr_addr.size() - base, v.n);
        for (int i = 0; i < v.n && base + i < wr_addr.size(); i++) begin
            check({tag, $sformatf(":addr%0d", i)}, wr_addr[base+i], 32'(4 * i));
            check({tag, $sformatf(":data%0d", i)}, wr_data[base+i], v.w[i]);
            check({tag, $sformatf(":len%0d", i)}, wr_len[base+i], v.ack_delay);
        end
        check({tag, ":write_cycles"}, write_cycles - wc_base, v.n * v.ack_delay);
        check({tag, ":addr_data_stable"}, unstable_cnt - us_base, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":rx_ready"}, bus.rx_ready, 1'b0);
        check({tag, ":mem_write"}, bus.mem_write, 1'b0);
        check({tag, ":mem_addr"}, bus.mem_addr, 32'h0);
        check({tag, ":mem_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, ":cpu_hold"}, cpu_hold, 1'b0);
        check({tag, ":busy"}, busy, 1'b0);
        check({tag, ":done"}, done, 1'b0);
        check({tag, ":error"}, error, 1'b0);
        check({tag, ":words_written"}, words_written, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int wc_base;
        int base;

        // Good image, ack always high (also outside WRITE).
        vecs[0] = '{n: 1, w: {32'h00A00513, 32'h0, 32'h0}, cs_mask: 8'h00, ack_delay: 1,
                    stray: 1'b1, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0,
                    exp_words: 16'd1, exp_end_addr: 32'h4};
        // Three words, memory stalls each write for 4 cycles.
        vecs[1] = '{n: 3, w: {32'h11223344, 32'hDEADBEEF, 32'h0000FFFF}, cs_mask: 8'h00,
                    ack_delay: 4, stray: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0,
                    exp_words: 16'd3, exp_end_addr: 32'hC};
        // Checksum off by one bit: words still written, load fails.
        vecs[2] = '{n: 2, w: {32'hCAFEF00D, 32'h12345678, 32'h0}, cs_mask: 8'h01, ack_delay: 1,
                    stray: 1'b0, exp_done: 1'b0, exp_error: 1'b1, exp_hold: 1'b1,
                    exp_words: 16'd2, exp_end_addr: 32'h8};
        // Empty image: checksum 0x00, no writes.
        vecs[3] = '{n: 0, w: {32'h0, 32'h0, 32'h0}, cs_mask: 8'h00, ack_delay: 1,
                    stray: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0,
                    exp_words: 16'd0, exp_end_addr: 32'h0};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clk);
        check("idle_rx_ready", bus.rx_ready, 1'b0);

        for (int k = 0; k < 4; k++) run_load(vecs[k], $sformatf("vec%0d", k));

        // Count 0x0101 exceeds MAX_WORDS: error right after the second byte.
        ack_delay = 1;
        stray_ack = 1'b0;
        wc_base   = write_cycles;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check("ovf:error", error, 1'b1);
        check("ovf:done", done, 1'b0);
        check("ovf:busy", busy, 1'b0);
        check("ovf:cpu_hold", cpu_hold, 1'b1);
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("ovf:rx_ready_stays_low", bus.rx_ready, 1'b0);
        check("ovf:words_written", words_written, 16'd0);
        bus.rx_valid = 1'b0;
        check("ovf:no_mem_write", write_cycles - wc_base, 0);

        // Start pulsed mid-load is ignored; bytes 11..88 -> two words, cs 0x8A.
        ack_delay = 2;
        base      = wr_addr.size();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        pulse_start();
        check("midstart:busy", busy, 1'b1);
        check("midstart:rx_ready", bus.rx_ready, 1'b1);
        check("midstart:words", words_written, 16'd0);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h8A);
        check("midstart:done", done, 1'b1);
        check("midstart:error", error, 1'b0);
        check("midstart:words_end", words_written, 16'd2);
        check("midstart:n_writes", wr_addr.size() - base, 2);
        if (wr_addr.size() - base == 2) begin
            check("midstart:data0", wr_data[base], 32'h44332211);
            check("midstart:data1", wr_data[base+1], 32'h88776655);
            check("midstart:addr1", wr_addr[base+1], 32'h4);
        end

        // Reset during the third payload byte aborts everything immediately.
        ack_delay = 1;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h05);
        bus.rx_data  = 8'hA0;
        bus.rx_valid = 1'b1;
        reset        = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        check("midrst:rx_ready_after_release", bus.rx_ready, 1'b0);
        run_load(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The CPU datapath only reads instruction memory; this block fills it with a program at run time.
- Receives a byte stream through a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive word addresses through a write/ack handshake, then verifies an XOR checksum.
- Holds the CPU stalled while loading and releases it when the checksum matches.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr.
- BASE_ADDR, 0, byte address of the first word written; must be 4-aligned.
- MAX_WORDS, 256, largest word count accepted; a larger count is an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- mem_addr  out  ADDR_WIDTH  instruction memory write byte address.
- mem_wdata  out  32  word to write.
- mem_write  out  1  write request (drives MemWrite).
- mem_ack  in  1  memory accepted the write.
- cpu_hold  out  1  stall CPU: gates PC enable and forces MemRead address mux to loader.
- busy  out  1  load in progress.
- done  out  1  last load completed with a good checksum.
- error  out  1  last load failed (count too large or checksum mismatch).
- words_written  out  16  number of words written in the current/last load.

Behaviour:
- Reset values (reset low, async): state IDLE, rx_ready=0, mem_write=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, words_written=0, checksum accumulator=0.
- Byte transfer occurs on a rising edge with rx_valid && rx_ready. rx_ready is a registered function of state: high only in CNT_LO, CNT_HI, BYTE, CHECK.
- Stream format: count low byte, count high byte (N, 16 bits), 4*N payload bytes (LSB first per word), 1 checksum byte. The checksum equals the XOR of all preceding bytes, count bytes included.
- States and transitions:
  - IDLE: on start go to CNT_LO; set busy=1, cpu_hold=1, done=0, error=0, words_written=0, mem_addr=BASE_ADDR, acc=0.
  - CNT_LO: on transfer latch N[7:0], acc^=byte, go to CNT_HI.
  - CNT_HI: on transfer latch N[15:8], acc^=byte.
    - If N>MAX_WORDS, go to ERROR.
    - Else if N==0, go to CHECK.
    - Else go to BYTE with byte_idx=0.
  - BYTE: on transfer place byte in mem_wdata[8*byte_idx +: 8], acc^=byte. byte_idx wraps 3->0; at 3 go to WRITE.
  - WRITE: mem_write=1, with mem_addr and mem_wdata stable until an edge where mem_ack=1. A mem_ack already high on the first WRITE cycle completes the write in one cycle. On ack: mem_write=0, mem_addr+=4, words_written+=1. If the new words_written==N go to CHECK, else go to BYTE.
  - CHECK: on transfer compare the byte with acc. Match: go to DONE (done=1, busy=0, cpu_hold=0). Mismatch: go to ERROR (error=1, busy=0, cpu_hold stays 1).
  - DONE / ERROR: outputs hold; start re-enters the IDLE start actions in the same edge.
- start is ignored while busy=1. A stray mem_ack outside WRITE is ignored. rx_valid with rx_ready=0 is not consumed.
- mem_addr wraps modulo 2^ADDR_WIDTH; there is no range check beyond MAX_WORDS.
- Reset asserted mid-load aborts immediately and returns all outputs to their reset values. Partially written memory is left as is.
- Latency: the first write request appears 1 cycle after the 6th accepted byte. Minimum cost is 5 cycles per word (4 bytes + 1 write).

Decomposition:
- Shared package constants: state encoding (IDLE, CNT_LO, CNT_HI, BYTE, WRITE, CHECK, DONE, ERROR, 3 bits) and WORD_BYTES=4.
- One natural sub-module, word_assembler: byte_idx counter plus 32-bit shift/insert register with clear and word_full outputs. Everything else stays in the FSM.

Test Plan:
- Stream 01 00 13 05 A0 00 (xor) with ack always high -> one write, mem_addr=0x0, mem_wdata=0x00A00513; done=1, cpu_hold=0, words_written=1.
- N=3 with mem_ack delayed 4 cycles per write -> mem_write held 4 cycles each, with addr/data stable; addresses 0x0, 0x4, 0x8; done=1.
- N=2 with the checksum byte off by one bit -> both words written; error=1, done=0, cpu_hold=1.
- Count 0x0101 (257) with MAX_WORDS=256 -> ERROR after the 2nd byte; no mem_write ever asserted; error=1.
- N=0, checksum 0x00 -> DONE with no writes, words_written=0. Then start again, and start pulsed mid-load -> ignored; a fresh load runs normally.
- reset low for 1 cycle during the 3rd payload byte -> all outputs at reset values, rx_ready=0; a following start plus a full stream completes with done=1.
